ram_s2p_stream_reader: RTL and testbench

- Read-side master for the simple dual-port byte-enable RAM. It drives the RAM's registered read port (address out, data back one cycle later).
- Accepts a burst command (start address, word count) and streams the words out on a valid/ready interface with full backpressure.
- Sits between the RAM and stream consumers (DMA, packet TX). The RAM write port stays with the producer.

---
 rtl/ram_s2p_stream_reader.sv | 166 ++++++++++++++++
 tb/tb_ram_s2p_stream_reader.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_s2p_stream_reader.sv
// ram_s2p_stream_reader: burst read master for the simple dual-port RAM.
// Takes a (start address, length) command, drives the RAM's registered read
// port and streams the words out on a valid/ready interface through a
// 2-entry skid FIFO with full backpressure.
// Optional macro RAM_S2P_STREAM_READER_LAST_EN adds m_last_o marking the
// final word of each burst.
module ram_s2p_stream_reader #(
  parameter int BYTE_WIDTH    = 8,
  parameter int BYTES_IN_WORD = 4,
  parameter int WORD_COUNT    = 256,
  localparam int ADDR_WIDTH   = $clog2(WORD_COUNT),
  localparam int WORD_WIDTH   = BYTE_WIDTH * BYTES_IN_WORD,
  localparam int LEN_WIDTH    = ADDR_WIDTH + 1
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [LEN_WIDTH-1:0]  cmd_len_i,
  output logic [ADDR_WIDTH-1:0] ram_addr_b_o,
  input  logic [WORD_WIDTH-1:0] ram_data_b_i,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [WORD_WIDTH-1:0] m_data_o,
`ifdef RAM_S2P_STREAM_READER_LAST_EN
  output logic                  m_last_o,
`endif
  output logic                  busy_o
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  remain_q;
  logic                  inflight_q;
  logic [WORD_WIDTH-1:0] fifoMem_q [2];
  logic                  wrPtr_q, rdPtr_q;
  logic [1:0]            count_q;

  logic                  accept;
  logic                  issue;
  logic                  push;
  logic                  pop;
  logic [2:0]            occupancy;
  logic [ADDR_WIDTH-1:0] nextAddr;
  logic                  lastIssue;

  assign accept    = cmd_valid_i && cmd_ready_o;
  assign push      = inflight_q;
  assign pop       = (count_q != 2'd0) && m_ready_i;
  // Words held or about to land, minus the one leaving this cycle; a new read
  // may only issue when this leaves room for it in the 2-entry FIFO.
  assign occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign nextAddr  = (addr_q == ADDR_WIDTH'(WORD_COUNT - 1)) ? '0 : addr_q + ADDR_WIDTH'(1);
  assign lastIssue = (remain_q == LEN_WIDTH'(1));

  assign ram_addr_b_o = addr_q;
  assign m_valid_o    = (count_q != 2'd0);
  assign m_data_o     = fifoMem_q[rdPtr_q];

  // State register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic: DRAIN exits in the cycle the last word pops.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (accept && (cmd_len_i != '0)) state_d = READ;
      READ:  if ((remain_q == '0) || (issue && lastIssue)) state_d = DRAIN;
      DRAIN: if (!inflight_q && ((count_q == 2'd0) || ((count_q == 2'd1) && pop)))
               state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs, including the read-issue credit check.
  always_comb begin
    cmd_ready_o = 1'b0;
    busy_o      = 1'b1;
    issue       = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready_o = 1'b1;
        busy_o      = 1'b0;
      end
      READ:  issue = (remain_q != '0) && (occupancy < 3'd2);
      default: ;
    endcase
  end

  // Burst address/length tracking; the address wraps at the RAM depth.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      addr_q     <= '0;
      remain_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (accept && (cmd_len_i != '0)) begin
        addr_q   <= cmd_addr_i;
        remain_q <= cmd_len_i;
      end else if (issue) begin
        addr_q   <= nextAddr;
        remain_q <= remain_q - LEN_WIDTH'(1);
      end
    end
  end

  // Capture FIFO: RAM data lands the cycle after its address was presented.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      fifoMem_q[0] <= '0;
      fifoMem_q[1] <= '0;
      wrPtr_q      <= 1'b0;
      rdPtr_q      <= 1'b0;
      count_q      <= 2'd0;
    end else begin
      if (push) begin
        fifoMem_q[wrPtr_q] <= ram_data_b_i;
        wrPtr_q            <= ~wrPtr_q;
      end
      if (pop) rdPtr_q <= ~rdPtr_q;
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef RAM_S2P_STREAM_READER_LAST_EN
  logic inflightLast_q;
  logic fifoLast_q [2];

  // Last-word flag travels alongside its data through the read pipe and FIFO.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      inflightLast_q <= 1'b0;
      fifoLast_q[0]  <= 1'b0;
      fifoLast_q[1]  <= 1'b0;
    end else begin
      inflightLast_q <= issue && lastIssue;
      if (push) fifoLast_q[wrPtr_q] <= inflightLast_q;
    end
  end

  assign m_last_o = m_valid_o && fifoLast_q[rdPtr_q];
`endif

`ifndef SYNTHESIS
  cmdValidKnown: assert property (@(posedge clk_i) disable iff (!rstn_i)
    !$isunknown(cmd_valid_i));
  cmdFieldsKnown: assert property (@(posedge clk_i) disable iff (!rstn_i)
    cmd_valid_i |-> !$isunknown({cmd_addr_i, cmd_len_i}));
  cmdLenLegal: assert property (@(posedge clk_i) disable iff (!rstn_i)
    (cmd_valid_i && cmd_ready_o) |-> (cmd_len_i <= LEN_WIDTH'(WORD_COUNT)));
  dataStable: assert property (@(posedge clk_i) disable iff (!rstn_i)
    (m_valid_o && !m_ready_i) |=> $stable(m_data_o));
`endif

endmodule

// File: tb/tb_ram_s2p_stream_reader.sv
// Directed self-checking bench for ram_s2p_stream_reader with a behavioural
// registered-read RAM preloaded with mem[k] = k.
module tb_ram_s2p_stream_reader;

  localparam int AW = 8;
  localparam int WW = 32;
  localparam int LW = 9;

  logic          clk;
  logic          rstn;
  logic          cmdValid;
  logic          cmdReady;
  logic [AW-1:0] cmdAddr;
  logic [LW-1:0] cmdLen;
  logic [AW-1:0] ramAddr;
  logic [WW-1:0] ramData;
  logic          mValid;
  logic          mReady;
  logic [WW-1:0] mData;
  logic          busy;
`ifdef RAM_S2P_STREAM_READER_LAST_EN
  logic          mLast;
`endif

  int errors = 0;
  int checks = 0;

  logic [WW-1:0] mem [256];

  ram_s2p_stream_reader dut (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .cmd_valid_i  (cmdValid),
    .cmd_ready_o  (cmdReady),
    .cmd_addr_i   (cmdAddr),
    .cmd_len_i    (cmdLen),
    .ram_addr_b_o (ramAddr),
    .ram_data_b_i (ramData),
    .m_valid_o    (mValid),
    .m_ready_i    (mReady),
    .m_data_o     (mData),
`ifdef RAM_S2P_STREAM_READER_LAST_EN
    .m_last_o     (mLast),
`endif
    .busy_o       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-read RAM model: data appears the cycle after the address.
  always_ff @(posedge clk) ramData <= mem[ramAddr];

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] simulation did not finish");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [AW-1:0] a, input logic [LW-1:0] l);
    cmdValid = v;
    cmdAddr  = a;
    cmdLen   = l;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    int got;
    logic stalled;
    logic [WW-1:0] heldData;
    logic [AW-1:0] wrapExp [4];

    for (int k = 0; k < 256; k++) mem[k] = WW'(k);
    rstn   = 1'b0;
    mReady = 1'b1;
    applyStimulus(1'b0, '0, '0);

    // Reset state
    tick;
    tick;
    checkOutput("rst_valid", 32'(mValid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_data", mData, 32'd0);
    checkOutput("rst_addr", 32'(ramAddr), 32'd0);
    rstn = 1'b1;
    tick;
    checkOutput("rst_cmd_ready", 32'(cmdReady), 32'd1);

    // Burst without backpressure: addr 0x10, len 4
    $display("[TB] burst addr=0x10 len=4");
    applyStimulus(1'b1, 8'h10, 9'd4);
    tick;
    applyStimulus(1'b0, '0, '0);
    checkOutput("b1_busy_c1", 32'(busy), 32'd1);
    checkOutput("b1_ready_c1", 32'(cmdReady), 32'd0);
    checkOutput("b1_addr_c1", 32'(ramAddr), 32'h10);
    checkOutput("b1_valid_c1", 32'(mValid), 32'd0);
    tick;
    checkOutput("b1_valid_c2", 32'(mValid), 32'd0);
    checkOutput("b1_addr_c2", 32'(ramAddr), 32'h11);
    tick;
    for (int i = 0; i < 4; i++) begin
      checkOutput("b1_valid", 32'(mValid), 32'd1);
      checkOutput("b1_data", mData, 32'(32'h10 + i));
      checkOutput("b1_busy", 32'(busy), 32'd1);
      tick;
    end
    checkOutput("b1_valid_end", 32'(mValid), 32'd0);
    checkOutput("b1_ready_end", 32'(cmdReady), 32'd1);
    checkOutput("b1_busy_end", 32'(busy), 32'd0);

    // Wrap-around: addr 254, len 4
    $display("[TB] wrap addr=254 len=4");
    wrapExp[0] = 8'd254;
    wrapExp[1] = 8'd255;
    wrapExp[2] = 8'd0;
    wrapExp[3] = 8'd1;
    applyStimulus(1'b1, 8'd254, 9'd4);
    tick;
    applyStimulus(1'b0, '0, '0);
    tick;
    tick;
    for (int i = 0; i < 4; i++) begin
      checkOutput("wrap_valid", 32'(mValid), 32'd1);
      checkOutput("wrap_data", mData, 32'(wrapExp[i]));
      tick;
    end
    checkOutput("wrap_valid_end", 32'(mValid), 32'd0);
    checkOutput("wrap_ready_end", 32'(cmdReady), 32'd1);

    // Backpressure: addr 0x20, len 8, ready pattern 1,0,0 repeating
    $display("[TB] backpressure addr=0x20 len=8");
    applyStimulus(1'b1, 8'h20, 9'd8);
    tick;
    applyStimulus(1'b0, '0, '0);
    got      = 0;
    stalled  = 1'b0;
    heldData = '0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      mReady = ((cyc % 3) == 0);
      if (stalled) begin
        checkOutput("bp_hold_valid", 32'(mValid), 32'd1);
        checkOutput("bp_hold_data", mData, heldData);
      end
      if (mValid && mReady) begin
        checkOutput("bp_word", mData, 32'(32'h20 + got));
        got++;
      end
      stalled  = mValid && !mReady;
      heldData = mData;
      tick;
    end
    mReady = 1'b1;
    checkOutput("bp_count", 32'(got), 32'd8);
    checkOutput("bp_busy_end", 32'(busy), 32'd0);

    // Zero length, then a new command on the very next cycle
    $display("[TB] zero length");
    checkOutput("zl_ready_pre", 32'(cmdReady), 32'd1);
    applyStimulus(1'b1, 8'd5, 9'd0);
    tick;
    checkOutput("zl_busy", 32'(busy), 32'd0);
    checkOutput("zl_valid", 32'(mValid), 32'd0);
    checkOutput("zl_ready", 32'(cmdReady), 32'd1);
    applyStimulus(1'b1, 8'd7, 9'd1);
    tick;
    applyStimulus(1'b0, '0, '0);
    checkOutput("zl_next_busy", 32'(busy), 32'd1);
    checkOutput("zl_next_valid_c1", 32'(mValid), 32'd0);
    tick;
    tick;
    checkOutput("zl_next_valid", 32'(mValid), 32'd1);
    checkOutput("zl_next_data", mData, 32'd7);
    tick;
    checkOutput("zl_next_valid_end", 32'(mValid), 32'd0);
    checkOutput("zl_next_ready_end", 32'(cmdReady), 32'd1);

    // Reset in the middle of a 16-word burst
    $display("[TB] reset mid-burst");
    applyStimulus(1'b1, 8'h40, 9'd16);
    tick;
    applyStimulus(1'b0, '0, '0);
    got = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (mValid) begin
        checkOutput("mb_word", mData, 32'(32'h40 + got));
        got++;
        if (got == 5) break;
      end
      tick;
    end
    checkOutput("mb_count", 32'(got), 32'd5);
    rstn = 1'b0;
    #1;
    checkOutput("mb_rst_valid", 32'(mValid), 32'd0);
    checkOutput("mb_rst_busy", 32'(busy), 32'd0);
    checkOutput("mb_rst_data", mData, 32'd0);
    tick;
    tick;
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      checkOutput("mb_post_valid", 32'(mValid), 32'd0);
    end
    checkOutput("mb_post_ready", 32'(cmdReady), 32'd1);
    applyStimulus(1'b1, 8'd0, 9'd2);
    tick;
    applyStimulus(1'b0, '0, '0);
    tick;
    tick;
    checkOutput("mb_new_valid0", 32'(mValid), 32'd1);
    checkOutput("mb_new_data0", mData, 32'd0);
    tick;
    checkOutput("mb_new_valid1", 32'(mValid), 32'd1);
    checkOutput("mb_new_data1", mData, 32'd1);
    tick;
    checkOutput("mb_new_valid_end", 32'(mValid), 32'd0);
    checkOutput("mb_new_ready_end", 32'(cmdReady), 32'd1);

`ifdef RAM_S2P_STREAM_READER_LAST_EN
    // Last flag on a 3-word and a 1-word burst
    $display("[TB] last flag");
    applyStimulus(1'b1, 8'h30, 9'd3);
    tick;
    applyStimulus(1'b0, '0, '0);
    tick;
    tick;
    for (int i = 0; i < 3; i++) begin
      checkOutput("last3_valid", 32'(mValid), 32'd1);
      checkOutput("last3_data", mData, 32'(32'h30 + i));
      checkOutput("last3_flag", 32'(mLast), (i == 2) ? 32'd1 : 32'd0);
      tick;
    end
    checkOutput("last3_flag_end", 32'(mLast), 32'd0);
    applyStimulus(1'b1, 8'h50, 9'd1);
    tick;
    applyStimulus(1'b0, '0, '0);
    tick;
    tick;
    checkOutput("last1_valid", 32'(mValid), 32'd1);
    checkOutput("last1_data", mData, 32'h50);
    checkOutput("last1_flag", 32'(mLast), 32'd1);
    tick;
    checkOutput("last1_flag_end", 32'(mLast), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
